pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl_if.sv | 49 ++++
 rtl/pc_ctrl.sv | 114 +++++++++++
 tb/tb_pc_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: bundle of all fetch-side signals of the PC controller.
//
// Handshake rules:
//   - A transfer happens in the cycle where valid and ready are both 1.
//   - Once a producer raises valid, it holds valid and its payload stable
//     until that transfer happens. The only exception is a redirect flush.
//   - The imem channel is req/ready. Each accepted request gets exactly
//     one rvalid pulse in some later cycle.
//   - The decode channel is if_valid/if_ready.
//   - redirect_valid is a single-cycle pulse. It has no ready signal.
//
// Signals:
//   imem_req/imem_addr          controller -> memory  fetch request
//   imem_ready                  memory -> controller  request accepted
//   imem_rvalid/imem_rdata      memory -> controller  response
//   redirect_valid/redirect_pc  core -> controller    new fetch target
//   if_valid/if_pc/if_instr     controller -> decode  buffered instruction
//   if_ready                    decode -> controller  instruction consumed
//   misalign_err                controller -> core    misaligned redirect pulse
//
// Modports:
//   master  the controller side
//   slave   the environment side (memory, core, decode)
interface pc_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        misalign_err;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr, misalign_err,
        input  imem_ready, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr, misalign_err,
        output imem_ready, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: single-outstanding instruction fetch controller.
//
// Operation:
//   - Issues one fetch at a time.
//   - Buffers the returned instruction until decode takes it.
//   - Handles redirects in every state. A response that is still in flight
//     when a redirect arrives is drained and discarded.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          pc_ctrl_if.master (imem, redirect and decode channels)
//   dbg_state_o  current FSM state:
//                IDLE=0, REQ=1, WAIT=2, HOLD=3, DRAIN=4
module pc_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_ctrl_if.master        bus,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        misalign_q, misalign_d;
    logic        redir_misaligned;
    logic [31:0] redirect_tgt;

    // A misaligned target is never fetched; the trap vector replaces it.
    assign redir_misaligned = (bus.redirect_pc[1:0] != 2'b00);
    assign redirect_tgt     = redir_misaligned ? TRAP_VECTOR : bus.redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_VECTOR;
            if_pc_q    <= RESET_VECTOR;
            if_instr_q <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        misalign_d = bus.redirect_valid && redir_misaligned;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                // If a redirect coincides with acceptance, the request is
                // already in flight. Its response must be drained.
                if (bus.imem_ready)
                    state_d = bus.redirect_valid ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    if (bus.redirect_valid) begin
                        state_d = S_REQ;
                    end else begin
                        if_pc_d    = pc_q;
                        if_instr_d = bus.imem_rdata;
                        pc_d       = pc_q + 32'd4;
                        state_d    = S_HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (bus.redirect_valid || bus.if_ready)
                    state_d = S_REQ;
            end
            S_DRAIN: begin
                if (bus.imem_rvalid)
                    state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase

        // A redirect overrides any pc update made in the state logic above.
        if (bus.redirect_valid)
            pc_d = redirect_tgt;
    end

    assign bus.imem_req     = (state_q == S_REQ);
    assign bus.imem_addr    = pc_q;
    assign bus.if_valid     = (state_q == S_HOLD);
    assign bus.if_pc        = if_pc_q;
    assign bus.if_instr     = if_instr_q;
    assign bus.misalign_err = misalign_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  pc_ctrl_if bus();

  pc_ctrl #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  // Reference model, transaction level.
  // exp_pc  : where the next fetch must go. It is the latest of
  //           "redirect target" and "delivered address + 4".
  // mem_*   : the single request the memory currently owes a response for.
  //           mem_kill marks a request that any redirect has overtaken.
  // exp_q   : holds {pc, instr} of the delivered instruction that decode
  //           has not yet taken.
  logic [31:0] exp_pc = RV;
  logic        exp_mis = 1'b0;
  logic        in_idle = 1'b1;
  logic        mem_busy = 1'b0;
  logic        mem_kill = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt = 0;
  int          fixed_lat = 0;
  logic [63:0] exp_q[$];

  logic        m_redir;
  logic [31:0] m_tgt;
  logic        m_exp_req;
  logic [63:0] m_head;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor and scoreboard. Runs on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("rst_imem_req", {31'b0, bus.imem_req}, 32'h0);
      check_eq("rst_if_valid", {31'b0, bus.if_valid}, 32'h0);
      check_eq("rst_misalign", {31'b0, bus.misalign_err}, 32'h0);
      check_eq("rst_if_pc", bus.if_pc, RV);
      check_eq("rst_if_instr", bus.if_instr, 32'h0);
      check_eq("rst_imem_addr", bus.imem_addr, RV);
      check_eq("rst_state_idle", {29'b0, dbg_state}, 32'h0);
      exp_pc   = RV;
      exp_mis  = 1'b0;
      in_idle  = 1'b1;
      mem_busy = 1'b0;
      mem_kill = 1'b0;
      exp_q.delete();
    end else begin
      check_eq("misalign_err", {31'b0, bus.misalign_err}, {31'b0, exp_mis});
      check_eq("if_valid", {31'b0, bus.if_valid}, {31'b0, (exp_q.size() != 0)});
      if (bus.if_valid && exp_q.size() != 0) begin
        m_head = exp_q[0];
        check_eq("if_pc", bus.if_pc, m_head[63:32]);
        check_eq("if_instr", bus.if_instr, m_head[31:0]);
      end
      m_exp_req = !in_idle && !mem_busy && (exp_q.size() == 0);
      check_eq("imem_req", {31'b0, bus.imem_req}, {31'b0, m_exp_req});
      if (bus.imem_req)
        check_eq("imem_addr", bus.imem_addr, exp_pc);

      m_redir = bus.redirect_valid;
      m_tgt   = (bus.redirect_pc[1:0] != 2'b00) ? TV : bus.redirect_pc;

      // Decode side: the held instruction leaves on consume or on a flush.
      if (exp_q.size() != 0 && (bus.if_ready || m_redir))
        void'(exp_q.pop_front());

      // Memory response: delivered only if no redirect has overtaken it.
      if (mem_busy && bus.imem_rvalid) begin
        if (!(mem_kill || m_redir)) begin
          exp_q.push_back({mem_addr, mem_word(mem_addr)});
          exp_pc = mem_addr + 32'd4;
        end
        mem_busy = 1'b0;
      end else if (mem_busy) begin
        mem_kill = mem_kill | m_redir;
        if (mem_cnt > 0) mem_cnt--;
      end else if (bus.imem_req && bus.imem_ready) begin
        mem_busy = 1'b1;
        mem_kill = m_redir;
        mem_addr = exp_pc;
        mem_cnt  = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 2);
      end

      if (m_redir) exp_pc = m_tgt;
      exp_mis = m_redir && (bus.redirect_pc[1:0] != 2'b00);
      in_idle = 1'b0;
    end
  end

  // Drive one cycle of inputs just after the rising edge.
  task automatic drive(input logic rdy, input logic ifr, input logic redir,
                       input logic [31:0] tgt, input logic spur);
    @(posedge clk);
    #1;
    bus.imem_ready     = rdy;
    bus.if_ready       = redir ? 1'b0 : ifr;
    bus.redirect_valid = redir;
    bus.redirect_pc    = redir ? tgt : $urandom;
    if (mem_busy) begin
      bus.imem_rvalid = (mem_cnt == 0);
      bus.imem_rdata  = (mem_cnt == 0) ? mem_word(mem_addr) : $urandom;
    end else begin
      bus.imem_rvalid = spur;
      bus.imem_rdata  = $urandom;
    end
  endtask

  task automatic run_plain(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic wait_busy();
    int k = 0;
    while (!mem_busy && k < 50) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      k++;
    end
    check_eq("wait_busy_timeout", {31'b0, mem_busy}, 32'h1);
  endtask

  // Reset pulse, with a stale response arriving while reset is held.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.imem_ready     = 1'b0;
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.imem_rvalid    = 1'b1;
    bus.imem_rdata     = $urandom;
    repeat (3) @(posedge clk);
    #1;
    bus.imem_rvalid = 1'b0;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    case ($urandom_range(0, 5))
      0: t = 32'hFFFF_FFFC;
      1: t = 32'hFFFF_FFF8;
      2: t = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
      default: t = 32'($urandom_range(0, 255)) << 2;
    endcase
    return t;
  endfunction

  initial begin
    bus.imem_ready     = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.if_ready       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Straight-line fetches with minimum latency; address 0 returns 32'h00500093.
    fixed_lat = 0;
    run_plain(8);

    // Redirect while a response is outstanding; the late response is dropped.
    fixed_lat = 3;
    wait_busy();
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b0);
    fixed_lat = 0;
    run_plain(8);

    // Misaligned redirect goes to the trap vector and pulses misalign_err.
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0042, 1'b0);
    run_plain(6);

    // Decode stalls with an instruction held.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    run_plain(4);

    // Fetch at the top of the address space wraps to zero.
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run_plain(8);

    // Reset while a response is outstanding.
    fixed_lat = 3;
    wait_busy();
    do_reset();
    fixed_lat = 0;
    run_plain(8);

    // Randomized traffic, with one reset in the middle.
    fixed_lat = -1;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
            $urandom_range(0, 11) == 0, rand_tgt(), $urandom_range(0, 7) == 0);
    end
    run_plain(10);

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
